// File: rtl/lc3b_types.sv
// Shared LC-3b cache-hierarchy types, including the L2 arbiter state and grant-side encodings.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_cache_line;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } lc3b_arb_state;

   typedef enum logic {
      ARB_SEL_I = 1'b0,
      ARB_SEL_D = 1'b1
   } lc3b_arb_sel;

endpackage

// File: rtl/l2_arbiter_rr_priority.sv
// Combinational round-robin pick between the I-side and D-side requesters.
module rr_priority
   import lc3b_types::*;
(
   input  logic        i_pending_i,
   input  logic        d_pending_i,
   input  lc3b_arb_sel last_grant_i,
   output logic        grant_valid_o,
   output lc3b_arb_sel grant_sel_o
);

   always_comb begin
      grant_valid_o = i_pending_i | d_pending_i;
      grant_sel_o   = ARB_SEL_I;
      // On a tie, the side that did not win last time goes next.
      if (i_pending_i && d_pending_i) begin
         grant_sel_o = (last_grant_i == ARB_SEL_I) ? ARB_SEL_D : ARB_SEL_I;
      end else if (d_pending_i) begin
         grant_sel_o = ARB_SEL_D;
      end
   end

endmodule

// File: rtl/l2_arbiter.sv
// Serializes I-side and D-side line transactions onto one lower-memory port, round-robin fair,
// holding the granted request in registers until the single downstream response returns.
module l2_arbiter
   import lc3b_types::*;
#(
   parameter int ADDR_WIDTH = $bits(lc3b_word),
   parameter int LINE_WIDTH = $bits(lc3b_cache_line)
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic [ADDR_WIDTH-1:0] i_address,
   input  logic                  i_read,
   input  logic                  i_write,
   input  logic [LINE_WIDTH-1:0] i_wdata,
   output logic                  i_resp,
   output logic [LINE_WIDTH-1:0] i_rdata,

   input  logic [ADDR_WIDTH-1:0] d_address,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic                  d_resp,
   output logic [LINE_WIDTH-1:0] d_rdata,

   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic                  mem_resp,
   input  logic [LINE_WIDTH-1:0] mem_rdata
);

   lc3b_arb_state         state_q, state_d;
   lc3b_arb_sel           last_grant_q, last_grant_d;
   logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
   logic                  mem_read_q, mem_read_d;
   logic                  mem_write_q, mem_write_d;
   logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

   logic                  grant_valid;
   lc3b_arb_sel           grant_sel;

   rr_priority u_rr_priority (
      .i_pending_i   (i_read | i_write),
      .d_pending_i   (d_read | d_write),
      .last_grant_i  (last_grant_q),
      .grant_valid_o (grant_valid),
      .grant_sel_o   (grant_sel)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         last_grant_q  <= ARB_SEL_D;
         mem_address_q <= '0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_wdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         mem_address_q <= mem_address_d;
         mem_read_q    <= mem_read_d;
         mem_write_q   <= mem_write_d;
         mem_wdata_q   <= mem_wdata_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      mem_address_d = mem_address_q;
      mem_read_d    = mem_read_q;
      mem_write_d   = mem_write_q;
      mem_wdata_d   = mem_wdata_q;
      i_resp        = 1'b0;
      d_resp        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (grant_valid) begin
               last_grant_d = grant_sel;
               // A side asserting both read and write is treated as a write.
               if (grant_sel == ARB_SEL_I) begin
                  state_d       = SERVE_I;
                  mem_address_d = i_address;
                  mem_wdata_d   = i_wdata;
                  mem_write_d   = i_write;
                  mem_read_d    = i_read & ~i_write;
               end else begin
                  state_d       = SERVE_D;
                  mem_address_d = d_address;
                  mem_wdata_d   = d_wdata;
                  mem_write_d   = d_write;
                  mem_read_d    = d_read & ~d_write;
               end
            end
         end
         SERVE_I: begin
            if (mem_resp) begin
               i_resp      = 1'b1;
               state_d     = IDLE;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
            end
         end
         SERVE_D: begin
            if (mem_resp) begin
               d_resp      = 1'b1;
               state_d     = IDLE;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign mem_address = mem_address_q;
   assign mem_read    = mem_read_q;
   assign mem_write   = mem_write_q;
   assign mem_wdata   = mem_wdata_q;
   assign i_rdata     = mem_rdata;
   assign d_rdata     = mem_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter with hand-computed expectations for each scenario.
module tb_l2_arbiter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [15:0]  i_address, d_address, mem_address;
   logic         i_read, i_write, d_read, d_write;
   logic [127:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
   logic         i_resp, d_resp, mem_read, mem_write, mem_resp;

   int n_chk  = 0;
   int n_pass = 0;

   localparam logic [127:0] LINE_A = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_BEEF;
   localparam logic [127:0] LINE_5 = {8{16'h5555}};
   localparam logic [127:0] LINE_B = 128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878;
   localparam logic [127:0] LINE_C = 128'hFFFF_0000_FFFF_0000_1234_5678_9ABC_DEF0;

   l2_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_address   (i_address),
      .i_read      (i_read),
      .i_write     (i_write),
      .i_wdata     (i_wdata),
      .i_resp      (i_resp),
      .i_rdata     (i_rdata),
      .d_address   (d_address),
      .d_read      (d_read),
      .d_write     (d_write),
      .d_wdata     (d_wdata),
      .d_resp      (d_resp),
      .d_rdata     (d_rdata),
      .mem_address (mem_address),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_wdata   (mem_wdata),
      .mem_resp    (mem_resp),
      .mem_rdata   (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic respond(input logic [127:0] line);
      mem_resp  = 1'b1;
      mem_rdata = line;
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      i_address = '0; i_read = 0; i_write = 0; i_wdata = '0;
      d_address = '0; d_read = 0; d_write = 0; d_wdata = '0;
      mem_resp = 0; mem_rdata = '0;

      // Reset state
      #12;
      chk("rst_mem_read",  128'(mem_read), 128'(1'b0));
      chk("rst_mem_write", 128'(mem_write), 128'(1'b0));
      chk("rst_mem_addr",  128'(mem_address), 128'(16'h0));
      chk("rst_mem_wdata", mem_wdata, 128'h0);
      chk("rst_i_resp",    128'(i_resp), 128'(1'b0));
      chk("rst_d_resp",    128'(d_resp), 128'(1'b0));
      rst_n = 1'b1;
      step();

      // I-side read alone; memory responds 3 cycles after the request
      i_read = 1; i_address = 16'h1230;
      step();
      chk("t1_mem_read", 128'(mem_read), 128'(1'b1));
      chk("t1_mem_addr", 128'(mem_address), 128'(16'h1230));
      chk("t1_mem_write", 128'(mem_write), 128'(1'b0));
      step(); step();
      chk("t1_i_resp_wait", 128'(i_resp), 128'(1'b0));
      step();
      respond(LINE_A);
      chk("t1_i_resp", 128'(i_resp), 128'(1'b1));
      chk("t1_i_rdata", i_rdata, LINE_A);
      chk("t1_d_resp", 128'(d_resp), 128'(1'b0));
      chk("t1_d_rdata_pass", d_rdata, LINE_A);
      i_read = 0;
      step();
      mem_resp = 0;
      chk("t1_mem_read_clr", 128'(mem_read), 128'(1'b0));
      chk("t1_i_resp_clr", 128'(i_resp), 128'(1'b0));
      step();

      // Fresh reset, then simultaneous I read and D write: I first
      rst_n = 0; #2; rst_n = 1;
      i_read = 1; i_address = 16'h2000;
      d_write = 1; d_address = 16'h4000; d_wdata = LINE_5;
      step();
      chk("t2_first_read", 128'(mem_read), 128'(1'b1));
      chk("t2_first_write", 128'(mem_write), 128'(1'b0));
      chk("t2_first_addr", 128'(mem_address), 128'(16'h2000));
      step();
      respond(LINE_B);
      chk("t2_i_resp", 128'(i_resp), 128'(1'b1));
      chk("t2_d_resp_wait", 128'(d_resp), 128'(1'b0));
      i_read = 0;
      step();
      mem_resp = 0;
      chk("t2_idle_write", 128'(mem_write), 128'(1'b0));
      step();
      chk("t2_d_write", 128'(mem_write), 128'(1'b1));
      chk("t2_d_read", 128'(mem_read), 128'(1'b0));
      chk("t2_d_addr", 128'(mem_address), 128'(16'h4000));
      chk("t2_d_wdata", mem_wdata, LINE_5);
      respond(LINE_C);
      chk("t2_d_resp", 128'(d_resp), 128'(1'b1));
      chk("t2_i_resp_off", 128'(i_resp), 128'(1'b0));
      d_write = 0;
      step();
      mem_resp = 0;
      step();

      // Both sides request continuously: grants alternate D, I, D, I
      d_read = 1; d_address = 16'h2222;
      step();
      i_read = 1; i_address = 16'h1111;
      for (int k = 0; k < 4; k++) begin
         logic is_d;
         is_d = (k % 2 == 0);
         chk($sformatf("t3_addr_%0d", k), 128'(mem_address), is_d ? 128'(16'h2222) : 128'(16'h1111));
         chk($sformatf("t3_read_%0d", k), 128'(mem_read), 128'(1'b1));
         step();
         respond(LINE_A);
         chk($sformatf("t3_i_resp_%0d", k), 128'(i_resp), 128'(!is_d));
         chk($sformatf("t3_d_resp_%0d", k), 128'(d_resp), 128'(is_d));
         if (k == 3) begin
            i_read = 0; d_read = 0;
         end
         step();
         mem_resp = 0;
         chk($sformatf("t3_gap_%0d", k), 128'(mem_read), 128'(1'b0));
         step();
      end
      chk("t3_no_more", 128'(mem_read | mem_write), 128'(1'b0));

      // D read+write together, then upstream changes while being served
      d_read = 1; d_write = 1; d_address = 16'h3000; d_wdata = LINE_B;
      step();
      chk("t4_write", 128'(mem_write), 128'(1'b1));
      chk("t4_read", 128'(mem_read), 128'(1'b0));
      d_address = 16'h3FFF; d_wdata = LINE_C; i_write = 1; i_address = 16'h7777;
      step();
      chk("t5_addr_hold", 128'(mem_address), 128'(16'h3000));
      chk("t5_wdata_hold", mem_wdata, LINE_B);
      step();
      chk("t5_addr_hold2", 128'(mem_address), 128'(16'h3000));
      respond(LINE_A);
      chk("t5_d_resp", 128'(d_resp), 128'(1'b1));
      chk("t5_i_resp", 128'(i_resp), 128'(1'b0));
      d_read = 0; d_write = 0; i_write = 0;
      step();
      mem_resp = 0;
      step();

      // Reset asserted mid SERVE_D with a write outstanding
      d_write = 1; d_address = 16'h4400; d_wdata = LINE_C;
      step();
      chk("t6_write_on", 128'(mem_write), 128'(1'b1));
      step();
      rst_n = 0;
      #1;
      chk("t6_rst_write", 128'(mem_write), 128'(1'b0));
      chk("t6_rst_read", 128'(mem_read), 128'(1'b0));
      chk("t6_rst_addr", 128'(mem_address), 128'(16'h0));
      chk("t6_rst_wdata", mem_wdata, 128'h0);
      mem_resp = 1;
      #1;
      chk("t6_no_d_resp", 128'(d_resp), 128'(1'b0));
      mem_resp = 0;
      i_read = 1; i_address = 16'h5000;
      rst_n = 1;
      step();
      chk("t6_tie_i_read", 128'(mem_read), 128'(1'b1));
      chk("t6_tie_i_addr", 128'(mem_address), 128'(16'h5000));
      chk("t6_tie_write", 128'(mem_write), 128'(1'b0));
      respond(LINE_B);
      chk("t6_i_resp", 128'(i_resp), 128'(1'b1));
      i_read = 0; d_write = 0;
      step();
      mem_resp = 0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
